// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D),
// with bounded D streaks and a wait timeout. Define ARB_PERF_CNT_EN for per-port stall counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       i_stall_cnt,
    output logic [31:0]       d_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_resp_d;
    logic [3:0]        r_streak;
    logic [7:0]        r_to_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_in_wait;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata_cap;

    assign w_in_wait   = (r_state == WAIT_I) || (r_state == WAIT_D);
    assign w_done      = w_in_wait && (mem_ack || w_timeout);
    // A timed-out access returns zero data instead of whatever is on the bus.
    assign w_rdata_cap = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && (!i_req || (r_streak < STREAK_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_state_next = WAIT_D;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_ack) begin
                    w_state_next = RESP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                // Requests still visible here belong to the access just served.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resp_d    <= 1'b0;
            r_streak    <= '0;
            r_to_cnt    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_resp_d    <= 1'b1;
                r_to_cnt    <= '0;
                if (!i_req) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else if (w_grant_i) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= i_addr;
                r_resp_d   <= 1'b0;
                r_to_cnt   <= '0;
                r_streak   <= '0;
            end

            if (w_done) begin
                r_mem_req <= 1'b0;
                if (!mem_ack) begin
                    r_err <= 1'b1;
                end
                if (!r_resp_d) begin
                    r_i_rdata <= w_rdata_cap;
                end else if (!r_mem_we) begin
                    r_d_rdata <= w_rdata_cap;
                end
            end else if (w_in_wait) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
        end
    end

    assign i_ready   = (r_state == RESP) && !r_resp_d;
    assign d_ready   = (r_state == RESP) && r_resp_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

`ifdef ARB_PERF_CNT_EN
    logic        w_i_own;
    logic        w_d_own;
    logic [31:0] r_i_stall_cnt;
    logic [31:0] r_d_stall_cnt;

    // A port is "served" while its own access is waiting on memory or responding.
    assign w_i_own = (r_state == WAIT_I) || ((r_state == RESP) && !r_resp_d);
    assign w_d_own = (r_state == WAIT_D) || ((r_state == RESP) && r_resp_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_stall_cnt <= '0;
            r_d_stall_cnt <= '0;
        end else begin
            if (i_req && !w_i_own) begin
                r_i_stall_cnt <= r_i_stall_cnt + 32'd1;
            end
            if (d_req && !w_d_own) begin
                r_d_stall_cnt <= r_d_stall_cnt + 32'd1;
            end
        end
    end

    assign i_stall_cnt = r_i_stall_cnt;
    assign d_stall_cnt = r_d_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model compared
// every cycle, a programmable-latency memory, and directed scenarios with literal checks.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   i_stall_cnt;
    logic [31:0]   d_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
`ifdef ARB_PERF_CNT_EN
        , .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory: ack arrives in the ack_cycle-th cycle of mem_req, or never when hung.
    logic [31:0] mem_arr [logic [31:0]];
    int ack_cycle = 1;
    bit mem_hang  = 0;
    bit late_ack  = 0;
    int req_cyc   = 0;

    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            req_cyc   = 0;
            mem_ack   = late_ack;
            mem_rdata = $urandom;
        end else begin
            req_cyc++;
            if (!mem_hang && req_cyc == ack_cycle) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Reference model: one outstanding access record, a wait count and a response flag.
    bit          m_busy, m_resp, m_is_d, m_we;
    logic [31:0] m_addr, m_wdata, e_i_rdata, e_d_rdata, m_data;
    bit          e_err;
    int          m_wait_n, m_streak;
    logic [31:0] m_i_stall, m_d_stall;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_is_d = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
            e_err = 0; m_wait_n = 0; m_streak = 0;
            m_i_stall = 0; m_d_stall = 0;
        end else begin
            if (i_req && !((m_busy || m_resp) && !m_is_d)) m_i_stall = m_i_stall + 1;
            if (d_req && !((m_busy || m_resp) && m_is_d))  m_d_stall = m_d_stall + 1;
            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (mem_ack || (m_wait_n + 1 == TO)) begin
                    m_data = mem_ack ? mem_rdata : 32'h0;
                    if (!mem_ack) e_err = 1;
                    if (!m_is_d)   e_i_rdata = m_data;
                    else if (!m_we) e_d_rdata = m_data;
                    m_busy = 0;
                    m_resp = 1;
                end else begin
                    m_wait_n++;
                end
            end else if (d_req && (!i_req || m_streak < MAXS)) begin
                m_busy = 1; m_is_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_wait_n = 0;
                m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (i_req) begin
                m_busy = 1; m_is_d = 0; m_we = 0; m_addr = i_addr;
                m_wait_n = 0; m_streak = 0;
            end
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_lit("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
            if (m_busy) begin
                check_lit("mem_we", {31'b0, mem_we}, {31'b0, m_we});
                check_lit("mem_addr", mem_addr, m_addr);
                if (m_we) check_lit("mem_wdata", mem_wdata, m_wdata);
            end
            check_lit("i_ready", {31'b0, i_ready}, {31'b0, m_resp && !m_is_d});
            check_lit("d_ready", {31'b0, d_ready}, {31'b0, m_resp && m_is_d});
            check_lit("both_ready", {31'b0, i_ready & d_ready}, 32'h0);
            check_lit("i_rdata", i_rdata, e_i_rdata);
            check_lit("d_rdata", d_rdata, e_d_rdata);
            check_lit("err", {31'b0, err}, {31'b0, e_err});
`ifdef ARB_PERF_CNT_EN
            check_lit("i_stall_cnt", i_stall_cnt, m_i_stall);
            check_lit("d_stall_cnt", d_stall_cnt, m_d_stall);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held until its ready pulse, released after the response cycle.
    task automatic run_access(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int req_cycles,
                              output logic [31:0] seen_addr, output logic seen_we,
                              output logic [31:0] seen_wdata, output int readies,
                              output int other_readies);
        req_cycles = 0; readies = 0; other_readies = 0;
        seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 0; k < 200; k++) begin
            tick();
            if (mem_req) begin
                req_cycles++;
                seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
            end
            if (is_d ? i_ready : d_ready) other_readies++;
            if (is_d ? d_ready : i_ready) begin
                readies++;
                break;
            end
        end
        tick();
        if (is_d ? i_ready : d_ready) other_readies++;
        if (is_d ? d_ready : i_ready) readies++;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    int          rc, nr, no, rises, r1, rise2, cyc;
    logic [31:0] sa, swd;
    logic        swe, prev_req;
    logic [31:0] grants [$];
    int          lead_d;

    initial begin
        mem_arr[32'h0]   = 32'h0BAD0000;
        mem_arr[32'hC]   = 32'hE3A01005;
        mem_arr[32'h40]  = 32'h55556666;
        mem_arr[32'h100] = 32'h11112222;
        mem_arr[32'h200] = 32'h33334444;

        // Reset state
        repeat (3) tick();
        check_lit("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check_lit("rst_mem_addr", mem_addr, 32'h0);
        check_lit("rst_mem_wdata", mem_wdata, 32'h0);
        check_lit("rst_i_rdata", i_rdata, 32'h0);
        check_lit("rst_err", {31'b0, err}, 32'h0);
        rst = 1'b1;
        tick();

        // Single fetch, ack in second wait cycle
        ack_cycle = 2;
        run_access(0, 0, 32'hC, 32'h0, rc, sa, swe, swd, nr, no);
        check_lit("fetch_addr", sa, 32'hC);
        check_lit("fetch_we", {31'b0, swe}, 32'h0);
        check_lit("fetch_req_cycles", rc, 2);
        check_lit("fetch_readies", nr, 1);
        check_lit("fetch_d_ready", no, 0);
        check_lit("fetch_rdata", i_rdata, 32'hE3A01005);
        $display("fetch addr=%h rdata=%h req_cycles=%0d", sa, i_rdata, rc);

        // Store then load on a 2-cycle memory
        run_access(1, 1, 32'h0, 32'h5, rc, sa, swe, swd, nr, no);
        check_lit("str_we", {31'b0, swe}, 32'h1);
        check_lit("str_wdata", swd, 32'h5);
        check_lit("str_readies", nr, 1);
        check_lit("str_d_rdata_kept", d_rdata, 32'h0);
        $display("store addr=%h wdata=%h", sa, swd);
        run_access(1, 0, 32'h0, 32'h0, rc, sa, swe, swd, nr, no);
        check_lit("ldr_rdata", d_rdata, 32'h5);
        $display("load addr=%h rdata=%h", sa, d_rdata);

        // Simultaneous requests with D kept busy: four D grants, then I
        ack_cycle = 1;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        prev_req = mem_req;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (mem_req && !prev_req) grants.push_back(mem_addr);
            prev_req = mem_req;
            if (i_ready) break;
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        lead_d = 0;
        foreach (grants[g]) begin
            if (grants[g] != 32'h200) break;
            lead_d++;
        end
        check_lit("starve_grants", grants.size(), 5);
        check_lit("starve_first", (grants.size() > 0) ? grants[0] : 32'hFFFFFFFF, 32'h200);
        check_lit("starve_lead_d", lead_d, 4);
        check_lit("starve_i_rdata", i_rdata, 32'h11112222);
        check_lit("starve_d_rdata", d_rdata, 32'h33334444);
        $display("starvation grants=%0d d_before_i=%0d", grants.size(), lead_d);

        // Back-to-back D with d_req held across the ready pulse
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        rises = 0; r1 = -100; rise2 = -1; nr = 0; cyc = 0;
        prev_req = mem_req;
        for (int k = 0; k < 50; k++) begin
            tick();
            cyc++;
            if (mem_req && !prev_req) begin
                rises++;
                if (rises == 2) rise2 = cyc;
            end
            prev_req = mem_req;
            if (d_ready) begin
                nr++;
                if (nr == 1) r1 = cyc;
                if (nr == 2) break;
            end
        end
        tick();
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_req && !prev_req) rises++;
            prev_req = mem_req;
        end
        check_lit("b2b_rises", rises, 2);
        check_lit("b2b_readies", nr, 2);
        check_lit("b2b_gap", rise2 - r1, 2);
        $display("back_to_back accesses=%0d gap=%0d", rises, rise2 - r1);

        // Timeout on a hung memory, then late acks ignored
        mem_hang = 1;
        run_access(0, 0, 32'h40, 32'h0, rc, sa, swe, swd, nr, no);
        check_lit("to_req_cycles", rc, 64);
        check_lit("to_readies", nr, 1);
        check_lit("to_i_rdata", i_rdata, 32'h0);
        check_lit("to_err", {31'b0, err}, 32'h1);
        mem_hang = 0;
        late_ack = 1;
        repeat (3) tick();
        late_ack = 0;
        check_lit("to_late_mem_req", {31'b0, mem_req}, 32'h0);
        run_access(0, 0, 32'hC, 32'h0, rc, sa, swe, swd, nr, no);
        check_lit("to_after_rdata", i_rdata, 32'hE3A01005);
        check_lit("to_err_sticky", {31'b0, err}, 32'h1);
        $display("timeout wait_cycles=%0d err=%0d", 64, err);

        // Reset in the middle of a D wait
        mem_hang = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_req) break;
        end
        check_lit("rst_mid_wait", {31'b0, mem_req}, 32'h1);
        repeat (2) tick();
        rst = 1'b0;
        d_req = 1'b0;
        tick();
        check_lit("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
        check_lit("rst_mid_d_ready", {31'b0, d_ready}, 32'h0);
        check_lit("rst_mid_err", {31'b0, err}, 32'h0);
        check_lit("rst_mid_i_rdata", i_rdata, 32'h0);
        rst = 1'b1;
        mem_hang = 0;
        tick();
        run_access(0, 0, 32'hC, 32'h0, rc, sa, swe, swd, nr, no);
        check_lit("rst_fetch_rdata", i_rdata, 32'hE3A01005);
        check_lit("rst_fetch_readies", nr, 1);
        $display("reset_mid_access fetch rdata=%h", i_rdata);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-ported unified memory between instruction fetch (I port) and load/store (D port).
- Sits between the fetch stage, the LDR/STR execute path and the memory model.
- Sequences each access as request, memory handshake, one-cycle response.
- Applies D-over-I priority with a bounded-starvation rule, and a wait timeout that flags a hung memory.

Parameters:
- ADDR_W, 32, address width for both ports and memory.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced; range 1..15.
- TIMEOUT_CYC, 64, maximum cycles in a wait state before aborting; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset (0 = reset).
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ready  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle pulse; load data valid or store done.
- d_rdata  out  DATA_W  load result.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including i_rdata, d_rdata, mem_addr, mem_wdata and err.
  - Streak counter and timeout counter go to 0.
  - Reset mid-access abandons the access with no ready pulse; mem_req is 0 in the first cycle after reset.
- States: IDLE, WAIT_I, WAIT_D, RESP.
- IDLE, arbitration sampled at the rising edge:
  - If d_req=1 and (i_req=0 or streak<MAX_D_STREAK): grant D, latch d_addr, d_we and d_wdata into the mem_* registers, go to WAIT_D.
  - Otherwise, if i_req=1: grant I, latch i_addr with mem_we=0, go to WAIT_I.
  - mem_req is registered high in the cycle after the grant.
- Streak counter:
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, or on a D grant while i_req=0.
  - Saturates at MAX_D_STREAK.
- WAIT_x:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held constant.
  - On mem_ack=1: capture mem_rdata into the granted port's rdata (stores leave d_rdata unchanged), drop mem_req at the same edge, go to RESP.
- RESP:
  - The granted port's ready=1 for exactly this cycle.
  - No arbitration in RESP; the old request still visible this cycle is ignored, which prevents duplicate service.
  - Always returns to IDLE next cycle.
  - Minimum turnaround is 3 cycles per access with a same-cycle mem_ack (grant edge, WAIT cycle, RESP cycle).
- Timeout:
  - The counter increments each WAIT cycle and clears on entering WAIT.
  - When it reaches TIMEOUT_CYC without ack: set err=1, drop mem_req, go to RESP, pulse ready with rdata=0 (stores: ready only).
  - A late mem_ack arriving in IDLE or RESP is ignored.
- Ready pulses: at most one of i_ready and d_ready per cycle; never both.
- i_rdata and d_rdata hold their last value until overwritten.
- Requests deasserted during WAIT are not cancelled: the access completes and ready still pulses.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs i_stall_cnt[31:0] and d_stall_cnt[31:0], reset to 0.
  - Each counts cycles where that port's req=1 and that port is not in WAIT_x or RESP for its own grant.
  - Both wrap modulo 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single fetch: i_req with i_addr=0x0000000C, mem_ack one cycle after mem_req rises, mem_rdata=0xE3A01005 -> mem_addr=0x0C, mem_we=0; i_ready pulses once with i_rdata=0xE3A01005; d_ready stays 0.
- Store then load, 2-cycle memory: STR d_addr=0x0, d_wdata=0x5, then LDR d_addr=0x0 -> first access mem_we=1 with mem_wdata=0x5 and d_ready pulses; second access d_rdata=0x00000005.
- Simultaneous requests, both held: i_req=1 and d_req=1 on the same edge -> D granted first; with D kept busy continuously, I is granted after exactly 4 D grants (MAX_D_STREAK=4).
- Back-to-back same port: d_req held high across d_ready -> no second mem_req until the cycle after RESP; exactly one access per request.
- Timeout: mem_ack tied 0, i_req=1 -> after 64 WAIT cycles err=1, i_ready pulses with i_rdata=0, mem_req drops; err stays 1 until rst=0.
- Reset mid-access: rst=0 in WAIT_D -> next cycle mem_req=0, d_ready=0, err=0, state IDLE; a following fetch completes normally.
